// File: rtl/bky_load_sched.sv
// Round-robin arbiter and START/SET_DONE sequencer for the shared BKY load engine,
// with a per-phase watchdog and triple-redundant, majority-voted control registers.
module bky_load_sched #(
   parameter int unsigned TMO_CYCLES = 2048
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o,
   output logic [1:0] done_o,
   output logic [1:0] err_o,
   output logic       eng_start_o,
   output logic       eng_rst_o,
   input  logic       eng_done_i,
   output logic       busy_o,
   output logic [2:0] state_o
);

   // Handshake: req_i is a level held until done_o/err_o; gnt_o is one-hot while the engine
   // belongs to that port, and exactly one of done_o/err_o pulses for one cycle as gnt_o drops.
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_GRANT   = 3'd1;
   localparam logic [2:0] S_RUN     = 3'd2;
   localparam logic [2:0] S_RELEASE = 3'd3;
   localparam logic [2:0] S_ABORT   = 3'd4;
   localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

   typedef struct packed {
      logic        last;
      logic [15:0] timer;
      logic [1:0]  gnt;
      logic [1:0]  done;
      logic [1:0]  err;
      logic        start;
      logic        eng_rst;
      logic        busy;
   } ctl_t;

   localparam ctl_t CTL_RST = '{last: 1'b1, timer: 16'd0, gnt: 2'b00, done: 2'b00,
                                err: 2'b00, start: 1'b0, eng_rst: 1'b0, busy: 1'b0};

   logic [2:0]  state0_q, state1_q, state2_q, state_v, state_d;
   ctl_t        ctl0_q, ctl1_q, ctl2_q, ctl_v, ctl_d;
   logic        tmo_hit;
   logic        win;
   logic [15:0] timer_inc;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state0_q <= S_IDLE;
         state1_q <= S_IDLE;
         state2_q <= S_IDLE;
         ctl0_q   <= CTL_RST;
         ctl1_q   <= CTL_RST;
         ctl2_q   <= CTL_RST;
      end else begin
         state0_q <= state_d;
         state1_q <= state_d;
         state2_q <= state_d;
         ctl0_q   <= ctl_d;
         ctl1_q   <= ctl_d;
         ctl2_q   <= ctl_d;
      end
   end

   // Bitwise 2-of-3 vote; a single upset copy is outvoted and rewritten on the next edge.
   assign state_v = (state0_q & state1_q) | (state0_q & state2_q) | (state1_q & state2_q);
   assign ctl_v   = ctl_t'((ctl0_q & ctl1_q) | (ctl0_q & ctl2_q) | (ctl1_q & ctl2_q));

   assign tmo_hit   = (ctl_v.timer == TMO_LAST);
   assign timer_inc = (ctl_v.timer == 16'hFFFF) ? ctl_v.timer : ctl_v.timer + 16'd1;
   assign win       = (req_i == 2'b11) ? ~ctl_v.last : req_i[1];

   always_comb begin
      state_d = state_v;
      case (state_v)
         S_IDLE:    if (|req_i) state_d = S_GRANT;
         S_GRANT:   state_d = S_RUN;
         S_RUN: begin
            if (eng_done_i)   state_d = S_RELEASE;
            else if (tmo_hit) state_d = S_ABORT;
         end
         S_RELEASE: begin
            if (!eng_done_i)  state_d = S_IDLE;
            else if (tmo_hit) state_d = S_ABORT;
         end
         S_ABORT:   if (ctl_v.timer == 16'd1) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ctl_d      = ctl_v;
      ctl_d.done = 2'b00;
      ctl_d.err  = 2'b00;
      ctl_d.busy = (state_d != S_IDLE);
      case (state_v)
         S_IDLE: begin
            ctl_d.start   = 1'b0;
            ctl_d.eng_rst = 1'b0;
            ctl_d.timer   = 16'd0;
            ctl_d.gnt     = (|req_i) ? (win ? 2'b10 : 2'b01) : 2'b00;
         end
         S_GRANT: begin
            ctl_d.start = 1'b1;
            ctl_d.timer = 16'd0;
         end
         S_RUN: begin
            if (eng_done_i) begin
               ctl_d.start = 1'b0;
               ctl_d.timer = 16'd0;
            end else if (tmo_hit) begin
               ctl_d.start   = 1'b0;
               ctl_d.eng_rst = 1'b1;
               ctl_d.timer   = 16'd0;
            end else begin
               ctl_d.timer = timer_inc;
            end
         end
         S_RELEASE: begin
            ctl_d.start = 1'b0;
            if (!eng_done_i) begin
               ctl_d.done  = ctl_v.gnt;
               ctl_d.gnt   = 2'b00;
               ctl_d.last  = ctl_v.gnt[1];
               ctl_d.timer = 16'd0;
            end else if (tmo_hit) begin
               ctl_d.eng_rst = 1'b1;
               ctl_d.timer   = 16'd0;
            end else begin
               ctl_d.timer = timer_inc;
            end
         end
         S_ABORT: begin
            ctl_d.start = 1'b0;
            // Timer counts the two reset cycles before the error is reported.
            if (ctl_v.timer == 16'd1) begin
               ctl_d.eng_rst = 1'b0;
               ctl_d.err     = ctl_v.gnt;
               ctl_d.gnt     = 2'b00;
               ctl_d.last    = ctl_v.gnt[1];
               ctl_d.timer   = 16'd0;
            end else begin
               ctl_d.timer = timer_inc;
            end
         end
         default: begin
            ctl_d.gnt     = 2'b00;
            ctl_d.start   = 1'b0;
            ctl_d.eng_rst = 1'b0;
            ctl_d.timer   = 16'd0;
         end
      endcase
   end

   assign gnt_o       = ctl_v.gnt;
   assign done_o      = ctl_v.done;
   assign err_o       = ctl_v.err;
   assign eng_start_o = ctl_v.start;
   assign eng_rst_o   = ctl_v.eng_rst;
   assign busy_o      = ctl_v.busy;
   assign state_o     = state_v;

endmodule

// File: tb/tb_bky_load_sched.sv
// Bench for bky_load_sched: a negedge-clocked engine model plus a transaction-level
// predictor that expands each grant into its expected per-cycle output timeline.
module tb_bky_load_sched;

   localparam int TMO = 400;
   localparam int W   = 9;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic       eng_done = 1'b0;
   logic [1:0] gnt, done, err;
   logic       eng_start, eng_rst, busy;
   logic [2:0] state;
   logic [W-1:0] obs;

   int total = 0;
   int bad = 0;
   logic [W-1:0] exp_q[$];
   bit model_last = 1'b1;

   int eng_d = 0;
   int eng_h = 1;
   int eng_cnt = 0;
   int eng_hcnt = 0;

   bky_load_sched #(.TMO_CYCLES(TMO)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_i       (req),
      .gnt_o       (gnt),
      .done_o      (done),
      .err_o       (err),
      .eng_start_o (eng_start),
      .eng_rst_o   (eng_rst),
      .eng_done_i  (eng_done),
      .busy_o      (busy),
      .state_o     (state)
   );

   assign obs = {gnt, done, err, eng_start, eng_rst, busy};

   // clock / time limit
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL time_limit got=running exp=finished");
      $fatal(1);
   end

   // engine model: raises SET_DONE after eng_d START cycles, drops it eng_h cycles after START falls
   always @(negedge clk) begin
      if (eng_rst) begin
         eng_done = 1'b0;
         eng_cnt  = 0;
         eng_hcnt = 0;
      end else if (eng_start) begin
         eng_cnt = eng_cnt + 1;
         if (eng_d > 0 && eng_cnt == eng_d) eng_done = 1'b1;
      end else begin
         eng_cnt = 0;
         if (eng_done) begin
            eng_hcnt = eng_hcnt + 1;
            if (eng_hcnt >= eng_h) begin
               eng_done = 1'b0;
               eng_hcnt = 0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pk(input logic [1:0] g, input logic [1:0] d,
                                       input logic [1:0] e, input logic s,
                                       input logic r, input logic b);
      return {g, d, e, s, r, b};
   endfunction

   task automatic step_check(input string tag);
      logic [W-1:0] e;
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check(tag, 32'(obs), 32'(e));
   endtask

   task automatic idle_cycles(input int n);
      req = 2'b00;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('0);
         step_check("idle");
      end
   endtask

   // One granted transaction; d==0 or d>TMO means the engine never finishes in time.
   task automatic run_txn(input logic [1:0] rv, input int d, input int h, input bit seu,
                          input bit jitter);
      int w, uk, last_k;
      bit ab;
      logic [1:0] one, wv;
      one = 2'b01;
      if (rv == 2'b11) w = model_last ? 0 : 1;
      else             w = rv[1] ? 1 : 0;
      wv = one << w;
      ab = (d == 0) || (d > TMO);
      if (!ab) begin
         uk = 1 + d;
         last_k = uk + h;
      end else begin
         uk = 1 + TMO;
         last_k = uk + 2;
      end
      for (int k = 0; k <= last_k; k++) begin
         if (k == 0)                     exp_q.push_back(pk(wv, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1));
         else if (k < uk)                exp_q.push_back(pk(wv, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
         else if (k < last_k)            exp_q.push_back(pk(wv, 2'b00, 2'b00, 1'b0, ab, 1'b1));
         else if (!ab)                   exp_q.push_back(pk(2'b00, wv, 2'b00, 1'b0, 1'b0, 1'b0));
         else                            exp_q.push_back(pk(2'b00, 2'b00, wv, 1'b0, 1'b0, 1'b0));
      end
      req = rv;
      eng_d = d;
      eng_h = h;
      for (int k = 0; k <= last_k; k++) begin
         step_check(seu ? "seu_txn" : (ab ? "abort_txn" : "done_txn"));
         if (seu && k == 10) force dut.state1_q = 3'b111;
         if (seu && k == uk) release dut.state1_q;
         if (jitter) req = 2'($urandom_range(0, 3));
      end
      model_last = (w == 1);
   endtask

   task automatic reset_mid_run(input logic [1:0] rv);
      int w;
      logic [1:0] one, wv;
      one = 2'b01;
      if (rv == 2'b11) w = model_last ? 0 : 1;
      else             w = rv[1] ? 1 : 0;
      wv = one << w;
      for (int k = 0; k <= 51; k++)
         exp_q.push_back(pk(wv, 2'b00, 2'b00, k > 0, 1'b0, 1'b1));
      req = rv;
      eng_d = 0;
      for (int k = 0; k <= 51; k++) step_check("pre_reset");
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_gnt", 32'(gnt), 32'd0);
      check("rst_async_start", 32'(eng_start), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      check("rst_async_done_err", 32'({done, err}), 32'd0);
      check("rst_async_state", 32'(state), 32'd0);
      req = 2'b00;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('0);
         step_check("in_reset");
      end
      rst_n = 1'b1;
      model_last = 1'b1;
   endtask

   initial begin
      logic [1:0] rv;
      int d, h, r;
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(obs), 32'd0);
      check("reset_state", 32'(state), 32'd0);
      rst_n = 1'b1;
      idle_cycles(2);

      run_txn(2'b01, 340, 3, 1'b0, 1'b0);
      idle_cycles(2);

      for (int i = 0; i < 4; i++)
         run_txn(2'b11, int'($urandom_range(1, 20)), int'($urandom_range(1, 4)), 1'b0, 1'b0);

      run_txn(2'b10, 0, 1, 1'b0, 1'b0);
      run_txn(2'b01, 5, 1, 1'b0, 1'b0);

      run_txn(2'b11, TMO, 2, 1'b0, 1'b0);
      run_txn(2'b11, TMO - 1, 1, 1'b0, 1'b0);
      run_txn(2'b01, TMO + 1, 1, 1'b0, 1'b0);

      reset_mid_run(2'b10);
      run_txn(2'b11, 8, 2, 1'b0, 1'b0);

      run_txn(2'b11, 60, 3, 1'b1, 1'b0);

      for (int i = 0; i < 25; i++) begin
         idle_cycles(int'($urandom_range(0, 2)));
         rv = 2'($urandom_range(1, 3));
         r  = int'($urandom_range(0, 9));
         d  = (r == 0) ? 0 : int'($urandom_range(1, 40));
         h  = int'($urandom_range(1, 4));
         run_txn(rv, d, h, 1'b0, 1'b1);
      end
      idle_cycles(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
